// File: rtl/dt_walk_classifier.sv
`default_nettype none
// ============================================================================
// Module  : dt_walk_classifier
// Brief   : Table-driven decision-tree classifier; sequential walker, one node per clock.
// Rev     : 1.0  initial release
// ============================================================================
module dt_walk_classifier #(
    parameter int N_FEAT  = 5,
    parameter int FEAT_W  = 32,
    parameter int DEPTH   = 4,
    parameter int CLASS_W = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N_FEAT*FEAT_W-1:0]             in_feat,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [CLASS_W-1:0]                   out_class,
    output logic [$clog2(DEPTH+1)-1:0]           out_depth,
    output logic                                 out_err,
    input  logic                                 cfg_we,
    input  logic [$clog2(2**DEPTH-1)-1:0]        cfg_addr,
    input  logic [1+$clog2(N_FEAT)+FEAT_W-1:0]   cfg_data,
    output logic                                 cfg_rej
);

    localparam int FIDX_W = $clog2(N_FEAT);
    localparam int NODES  = 2**DEPTH - 1;
    localparam int AW     = $clog2(NODES);
    localparam int NODE_W = 1 + FIDX_W + FEAT_W;
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam logic [NODE_W-1:0] NODE_RST = {1'b1, {(NODE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q;
    logic [NODE_W-1:0]         tbl_q [NODES];
    logic [N_FEAT*FEAT_W-1:0]  feat_q;
    logic [AW:0]               node_q;
    logic [LVL_W-1:0]          level_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic [CLASS_W-1:0]        out_class_q;
    logic [LVL_W-1:0]          out_depth_q;
    logic                      out_err_q;
    logic                      cfg_rej_q;

    logic [NODE_W-1:0]         node_w;
    logic                      n_leaf;
    logic [FIDX_W-1:0]         n_idx;
    logic [FEAT_W-1:0]         n_thr;
    logic [FEAT_W-1:0]         feat_sel;
    logic                      bad_idx;
    logic                      last_lvl;
    logic                      stop_w;
    logic                      err_w;
    logic [AW:0]               node_d;
    logic                      cfg_ok;

    // Out-of-range index reads as a default leaf; legal trees never get there.
    assign node_w   = (node_q < (AW+1)'(NODES)) ? tbl_q[node_q[AW-1:0]] : NODE_RST;
    assign n_leaf   = node_w[NODE_W-1];
    assign n_idx    = node_w[FEAT_W +: FIDX_W];
    assign n_thr    = node_w[FEAT_W-1:0];
    assign bad_idx  = 32'(n_idx) >= N_FEAT;
    assign last_lvl = (level_q == LVL_W'(DEPTH - 1));
    assign stop_w   = n_leaf || last_lvl || bad_idx;
    assign err_w    = bad_idx || (!n_leaf && last_lvl);
    assign cfg_ok   = (state_q == S_IDLE) && (cfg_addr < AW'(NODES));

    always_comb begin
        feat_sel = '0;
        for (int k = 0; k < N_FEAT; k++) begin
            if (n_idx == FIDX_W'(k)) begin
                feat_sel = feat_q[k*FEAT_W +: FEAT_W];
            end
        end
    end

    // Heap children: left = 2n+1 when feature is strictly below threshold, else right = 2n+2.
    assign node_d = {node_q[AW-1:0], 1'b0} + ((feat_sel < n_thr) ? (AW+1)'(1) : (AW+1)'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            feat_q      <= '0;
            node_q      <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_depth_q <= '0;
            out_err_q   <= 1'b0;
            cfg_rej_q   <= 1'b0;
            for (int i = 0; i < NODES; i++) begin
                tbl_q[i] <= NODE_RST;
            end
        end else begin
            cfg_rej_q <= cfg_we && !cfg_ok;
            if (cfg_we && cfg_ok) begin
                tbl_q[cfg_addr] <= cfg_data;
            end
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        feat_q     <= in_feat;
                        node_q     <= '0;
                        level_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (stop_w) begin
                        out_class_q <= n_thr[CLASS_W-1:0];
                        out_depth_q <= level_q;
                        out_err_q   <= err_w;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        node_q  <= node_d;
                        level_q <= level_q + LVL_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_depth = out_depth_q;
    assign out_err   = out_err_q;
    assign cfg_rej   = cfg_rej_q;

endmodule
`default_nettype wire

// File: tb/tb_dt_walk_classifier.sv
`default_nettype none
// ============================================================================
// Module  : tb_dt_walk_classifier
// Brief   : Scoreboard bench for dt_walk_classifier with directed vectors.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dt_walk_classifier;

    localparam int N_FEAT  = 5;
    localparam int FEAT_W  = 32;
    localparam int DEPTH   = 4;
    localparam int CLASS_W = 8;
    localparam int AW      = 4;
    localparam int NODE_W  = 1 + 3 + FEAT_W;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        in_valid = 1'b0;
    logic                        in_ready;
    logic [N_FEAT*FEAT_W-1:0]    in_feat = '0;
    logic                        out_valid;
    logic                        out_ready = 1'b1;
    logic [CLASS_W-1:0]          out_class;
    logic [2:0]                  out_depth;
    logic                        out_err;
    logic                        cfg_we = 1'b0;
    logic [AW-1:0]               cfg_addr = '0;
    logic [NODE_W-1:0]           cfg_data = '0;
    logic                        cfg_rej;

    typedef struct packed {
        logic [7:0] cls;
        logic [2:0] dep;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    dt_walk_classifier #(
        .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .DEPTH(DEPTH), .CLASS_W(CLASS_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_depth(out_depth), .out_err(out_err),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_rej(cfg_rej)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation on every output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got class %0h with empty scoreboard", out_class);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_class", 64'(out_class), 64'(e.cls));
                chk("out_depth", 64'(out_depth), 64'(e.dep));
                chk("out_err",   64'(out_err),   64'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_FEAT*FEAT_W-1:0] mk(input logic [31:0] x1, x2, x3, x4, x5);
        return {x5, x4, x3, x2, x1};
    endfunction

    task automatic wr(input int addr, input logic leaf, input logic [2:0] idx,
                      input logic [31:0] thr, input logic exp_rej);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_data = {leaf, idx, thr};
        tick();
        cfg_we   = 1'b0;
        chk("cfg_rej", 64'(cfg_rej), 64'(exp_rej));
    endtask

    task automatic issue(input logic [N_FEAT*FEAT_W-1:0] f, input logic [7:0] c,
                         input logic [2:0] d, input logic e);
        int n;
        exp_t x;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        x.cls = c;
        x.dep = d;
        x.err = e;
        sb.push_back(x);
        in_valid = 1'b1;
        in_feat  = f;
        tick();
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_done(input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        chk("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
        if (out_ready) tick();
    endtask

    task automatic run(input logic [N_FEAT*FEAT_W-1:0] f, input logic [7:0] c,
                       input logic [2:0] d, input logic e);
        issue(f, c, d, e);
        wait_done(int'(d) + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        rst = 1'b0;
        // T1: reset state and default tree
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_class", 64'(out_class), 64'd0);
        chk("rst_out_depth", 64'(out_depth), 64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);
        chk("rst_cfg_rej",   64'(cfg_rej),   64'd0);
        run(mk(0, 0, 0, 0, 0), 8'd0, 3'd0, 1'b0);

        // T2: small tree on x4 then x1
        wr(0, 1'b0, 3'd3, 32'd23, 1'b0);
        wr(1, 1'b0, 3'd0, 32'd9,  1'b0);
        wr(2, 1'b1, 3'd0, 32'd1,  1'b0);
        wr(3, 1'b1, 3'd0, 32'd0,  1'b0);
        wr(4, 1'b1, 3'd0, 32'd1,  1'b0);
        run(mk(5, 0, 0, 10, 0), 8'd0, 3'd2, 1'b0);
        run(mk(9, 0, 0, 10, 0), 8'd1, 3'd2, 1'b0);
        run(mk(0, 0, 0, 23, 0), 8'd1, 3'd1, 1'b0);
        run(mk(32'hFFFF_FFFF, 0, 0, 22, 0), 8'd1, 3'd2, 1'b0);

        // T3: back-pressure holds the result and blocks new samples
        out_ready = 1'b0;
        issue(mk(9, 0, 0, 10, 0), 8'd1, 3'd2, 1'b0);
        wait_done(3);
        in_valid = 1'b1;
        in_feat  = mk(0, 0, 0, 23, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid",    64'(out_valid), 64'd1);
            chk("hold_class",    64'(out_class), 64'd1);
            chk("hold_in_ready", 64'(in_ready),  64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("post_hold_in_ready", 64'(in_ready), 64'd1);

        // T4: writes rejected while walking or out of range
        issue(mk(5, 0, 0, 10, 0), 8'd0, 3'd2, 1'b0);
        wr(2, 1'b1, 3'd0, 32'd5, 1'b1);
        tick();
        chk("rej_pulse", 64'(cfg_rej), 64'd0);
        wait_done(3);
        run(mk(0, 0, 0, 23, 0), 8'd1, 3'd1, 1'b0);
        wr(15, 1'b1, 3'd0, 32'd7, 1'b1);

        // T5: internal node on the last level and bad feature index
        wr(0, 1'b0, 3'd0, 32'd1,     1'b0);
        wr(1, 1'b0, 3'd0, 32'd1,     1'b0);
        wr(3, 1'b0, 3'd0, 32'd1,     1'b0);
        wr(7, 1'b0, 3'd0, 32'h2A,    1'b0);
        run(mk(0, 0, 0, 0, 0), 8'h2A, 3'd3, 1'b1);
        wr(0, 1'b0, 3'd7, 32'h133,   1'b0);
        run(mk(0, 0, 0, 0, 0), 8'h33, 3'd0, 1'b1);

        // T6: reset mid-walk drops the result and restores the table
        wr(0, 1'b0, 3'd0, 32'd1, 1'b0);
        issue(mk(0, 0, 0, 0, 0), 8'h2A, 3'd3, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        run(mk(0, 0, 0, 0, 0), 8'd0, 3'd0, 1'b0);

        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
